// File: rtl/logic_op_pkg.sv
// Shared definitions for the AND/OR command issuer.
// Opcodes, FSM states and opcode legality helper.
package logic_op_pkg;

  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic op_legal(
    input logic [1:0] op
  );
    return (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/logic_op_cmd_fifo.sv
// Small command FIFO for the AND/OR issuer.
// Registered pointers, synchronous write, head shown on data_o.
module logic_op_cmd_fifo
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  // A full FIFO refuses pushes even when a pop frees a slot
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer and occupancy; pointers wrap modulo DEPTH
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/logic_op_issuer.sv
// Command front-end for the combinational AND/OR unit.
// Queues commands, drives the unit, returns registered responses.
module logic_op_issuer
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [WIDTH-1:0] cmdA,
  input  logic [WIDTH-1:0] cmdB,
  input  logic [1:0]       cmdOp,
  output logic [WIDTH-1:0] aIn,
  output logic [WIDTH-1:0] bIn,
  output logic             doAnd,
  output logic             doOr,
  input  logic             isAnd,
  input  logic [WIDTH-1:0] out,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspData,
  output logic             rspIsAnd,
  output logic             rspErr
);

  localparam int EW = 2*WIDTH + 2;
  localparam int CW = $clog2(DEPTH+1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             and_q, or_q;
  logic [1:0]       op_q;
  logic             vld_q;
  logic [WIDTH-1:0] dat_q;
  logic             isand_q;
  logic             err_q;

  logic [EW-1:0]    fifo_in;
  logic [EW-1:0]    fifo_hd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic             push;
  logic             pop;
  logic             cap;
  logic             rsp_clr;

  logic [1:0]       hd_op;
  logic [WIDTH-1:0] hd_a;
  logic [WIDTH-1:0] hd_b;

  assign cmdReady = !fifo_full;
  assign push     = cmdValid && cmdReady;
  assign fifo_in  = {cmdOp, cmdA, cmdB};

  assign hd_op = fifo_hd[EW-1 -: 2];
  assign hd_a  = fifo_hd[2*WIDTH-1 -: WIDTH];
  assign hd_b  = fifo_hd[WIDTH-1:0];

  logic_op_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .data_o  (fifo_hd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Full flag and occupancy must always agree
  assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_cnt == CW'(DEPTH)));

  // Next state and per-cycle control strobes
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap     = 1'b0;
    rsp_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cap     = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rspReady) begin
          rsp_clr = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Unit drive: load on pop, strobes drop once the result is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      and_q <= 1'b0;
      or_q  <= 1'b0;
      op_q  <= 2'b00;
    end else if (pop) begin
      a_q   <= hd_a;
      b_q   <= hd_b;
      and_q <= hd_op[0];
      or_q  <= hd_op[1];
      op_q  <= hd_op;
    end else if (cap) begin
      and_q <= 1'b0;
      or_q  <= 1'b0;
    end
  end

  // Response capture; held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      dat_q   <= '0;
      isand_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (cap) begin
      vld_q   <= 1'b1;
      dat_q   <= out;
      isand_q <= op_legal(op_q) ? isAnd : 1'b0;
      err_q   <= !op_legal(op_q);
    end else if (rsp_clr) begin
      vld_q   <= 1'b0;
    end
  end

  assign aIn      = a_q;
  assign bIn      = b_q;
  assign doAnd    = and_q;
  assign doOr     = or_q;
  assign rspValid = vld_q;
  assign rspData  = dat_q;
  assign rspIsAnd = isand_q;
  assign rspErr   = err_q;

endmodule

// File: tb/tb_logic_op_issuer.sv
// Bench for logic_op_issuer with a model of the AND/OR unit.
// Directed table, backpressure, reset and random traffic.
module tb_logic_op_issuer;

  logic       clk;
  logic       rst_n;
  logic       cmdValid;
  logic       cmdReady;
  logic [3:0] cmdA;
  logic [3:0] cmdB;
  logic [1:0] cmdOp;
  logic [3:0] aIn;
  logic [3:0] bIn;
  logic       doAnd;
  logic       doOr;
  logic       isAnd;
  logic [3:0] out;
  logic       rspValid;
  logic       rspReady;
  logic [3:0] rspData;
  logic       rspIsAnd;
  logic       rspErr;

  int total;
  int bad;

  typedef struct packed {
    logic [3:0] d;
    logic       ia;
    logic       e;
  } rsp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] d;
    logic       ia;
    logic       e;
  } vec_t;

  rsp_t exp_q[$];
  vec_t vt[6];

  logic_op_issuer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdA     (cmdA),
    .cmdB     (cmdB),
    .cmdOp    (cmdOp),
    .aIn      (aIn),
    .bIn      (bIn),
    .doAnd    (doAnd),
    .doOr     (doOr),
    .isAnd    (isAnd),
    .out      (out),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspData  (rspData),
    .rspIsAnd (rspIsAnd),
    .rspErr   (rspErr)
  );

  // AND/OR unit: exactly one strobe selects an op, otherwise 0
  always_comb begin
    out   = 4'h0;
    isAnd = 1'b0;
    if (doAnd && !doOr) begin
      out   = aIn & bIn;
      isAnd = 1'b1;
    end else if (doOr && !doAnd) begin
      out = aIn | bIn;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic rsp_t model(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [1:0] op
  );
    rsp_t r;
    case (op)
      2'b01:   r = '{d: a & b, ia: 1'b1, e: 1'b0};
      2'b10:   r = '{d: a | b, ia: 1'b0, e: 1'b0};
      default: r = '{d: 4'h0, ia: 1'b0, e: 1'b1};
    endcase
    return r;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Inputs are already set; record handshakes, then advance a cycle
  task automatic tick();
    logic fc;
    logic fr;
    rsp_t e;
    fc = cmdValid && cmdReady;
    fr = rspValid && rspReady;
    if (fr) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", rspData, e.d);
        chk("sb_isand", rspIsAnd, e.ia);
        chk("sb_err", rspErr, e.e);
      end
    end
    if (fc) begin
      exp_q.push_back(model(cmdA, cmdB, cmdOp));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] held_d;
    int n;
    total = 0;
    bad   = 0;
    vt[0] = '{4'hC, 4'hA, 2'b01, 4'h8, 1'b1, 1'b0};
    vt[1] = '{4'hC, 4'h3, 2'b10, 4'hF, 1'b0, 1'b0};
    vt[2] = '{4'hF, 4'hF, 2'b11, 4'h0, 1'b0, 1'b1};
    vt[3] = '{4'h9, 4'h6, 2'b00, 4'h0, 1'b0, 1'b1};
    vt[4] = '{4'hF, 4'h5, 2'b01, 4'h5, 1'b1, 1'b0};
    vt[5] = '{4'h0, 4'h0, 2'b10, 4'h0, 1'b0, 1'b0};

    rst_n    = 1'b1;
    cmdValid = 1'b0;
    cmdA     = 4'h0;
    cmdB     = 4'h0;
    cmdOp    = 2'b00;
    rspReady = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_cmdReady", cmdReady, 1);
    chk("rst_aIn", aIn, 0);
    chk("rst_bIn", bIn, 0);
    chk("rst_rspData", rspData, 0);
    chk("rst_strobes", {doAnd, doOr, rspIsAnd, rspErr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: latency and results with rspReady high
    rspReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmdA     = vt[i].a;
      cmdB     = vt[i].b;
      cmdOp    = vt[i].op;
      cmdValid = 1'b1;
      tick();
      cmdValid = 1'b0;
      chk("lat0_vld", rspValid, 0);
      tick();
      chk("drv_vld", rspValid, 0);
      chk("drv_and", doAnd, vt[i].op[0]);
      chk("drv_or", doOr, vt[i].op[1]);
      chk("drv_a", aIn, vt[i].a);
      chk("drv_b", bIn, vt[i].b);
      tick();
      chk("rsp_vld", rspValid, 1);
      chk("rsp_data", rspData, vt[i].d);
      chk("rsp_isand", rspIsAnd, vt[i].ia);
      chk("rsp_err", rspErr, vt[i].e);
      chk("rsp_strobes", {doAnd, doOr}, 0);
      tick();
      chk("after_vld", rspValid, 0);
    end

    // Backpressure: fill one in flight plus four queued
    rspReady = 1'b0;
    cmdValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmdA  = 4'(i + 3);
      cmdB  = 4'(9 - i);
      cmdOp = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("fill_ready", cmdReady, 1);
      tick();
    end
    chk("full_ready", cmdReady, 0);
    chk("full_vld", rspValid, 1);
    chk("full_q", exp_q.size(), 5);
    held_d = rspData;
    chk("full_head", rspData, exp_q[0].d);
    // Sixth command is offered but must be held off while stalled
    cmdA  = 4'hE;
    cmdB  = 4'h1;
    cmdOp = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_vld", rspValid, 1);
      chk("stall_data", rspData, held_d);
      chk("stall_isand", rspIsAnd, exp_q[0].ia);
      chk("stall_err", rspErr, exp_q[0].e);
      chk("stall_strobes", {doAnd, doOr}, 0);
      chk("stall_ready", cmdReady, 0);
    end
    chk("stall_q", exp_q.size(), 5);
    cmdValid = 1'b0;
    rspReady = 1'b1;
    n = 0;
    while (n < 40 && exp_q.size() != 0) begin
      tick();
      n++;
    end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_cycles", n, 9);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      cmdValid = 1'($urandom_range(0, 1));
      cmdA     = 4'($urandom);
      cmdB     = 4'($urandom);
      cmdOp    = 2'($urandom_range(0, 3));
      rspReady = ($urandom_range(0, 3) != 0);
      if (rspValid) begin
        chk("rnd_strobes", {doAnd, doOr}, 0);
      end
      tick();
    end
    cmdValid = 1'b0;
    rspReady = 1'b1;
    n = 0;
    while (n < 60 && exp_q.size() != 0) begin
      tick();
      n++;
    end
    chk("rnd_drain", exp_q.size(), 0);

    // Reset while a response waits and three commands are queued
    rspReady = 1'b0;
    cmdValid = 1'b1;
    cmdOp    = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cmdA = 4'(i + 8);
      cmdB = 4'hF;
      tick();
    end
    cmdValid = 1'b0;
    chk("pre_rst_vld", rspValid, 1);
    chk("pre_rst_q", exp_q.size(), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", rspValid, 0);
    chk("mid_rst_ready", cmdReady, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    rspReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_vld", rspValid, 0);
      tick();
    end

    // Still operational after reset
    cmdA     = 4'h3;
    cmdB     = 4'h6;
    cmdOp    = 2'b10;
    cmdValid = 1'b1;
    tick();
    cmdValid = 1'b0;
    n = 0;
    while (n < 10 && exp_q.size() != 0) begin
      tick();
      n++;
    end
    chk("post_rst_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
